cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbiter for the single common data bus (CDB). The ALU path (out of the RS) and the LSB can
//  both complete in the same cycle. This block queues each producer's results and grants one
//  per cycle, round-robin. It drives one registered broadcast to the RS, LSB and ROB wake-up
//  logic, and back-pressures a producer whose queue is full. Sits between ALU/LSB outputs
//  and every CDB consumer.
// PARAMETERS
//  BUF_BIT    2   log2 of the per-producer queue depth (DEPTH = 1<<BUF_BIT = 4)
//  ROB_W      `robsize   ROB index width (from const.v)
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous active-high reset
//  rdy            in   1      global enable; when low, all state holds
//  clear          in   1      pipeline flush (mispredict); drops all queued and incoming results
//  alu_valid      in   1      ALU result valid this cycle
//  alu_rob_id     in   ROB_W  ALU result tag
//  alu_value      in   32     ALU result value
//  alu_full       out  1      ALU queue full; ALU must not issue (RS holds shot)
//  lsb_valid      in   1      LSB result valid this cycle
//  lsb_rob_id     in   ROB_W  LSB result tag
//  lsb_value      in   32     LSB result value
//  lsb_full       out  1      LSB queue full; LSB must not complete
//  cdb_valid      out  1      broadcast valid (registered)
//  cdb_rob_id     out  ROB_W  broadcast tag
//  cdb_value      out  32     broadcast value
//  cdb_src        out  1      0 = ALU, 1 = LSB (debug/ROB stats)
// BEHAVIOUR
//  - Reset: cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0; both queues empty;
//    alu_full=lsb_full=0; last_grant=1, so the ALU wins the first tie.
//  - All registers update only when rdy=1. rst takes priority over rdy and clear.
//  - Per-producer candidate: the queue head if the queue is non-empty, else the incoming
//    valid (bypass).
//    - A valid input whose candidate loses, or that arrives while its queue is non-empty,
//      is enqueued.
//  - Grant: one candidate -> it wins. Two candidates -> the source != last_grant wins;
//    last_grant <= winner. No candidate -> cdb_valid <= 0 and last_grant is unchanged.
//  - Latency: an uncontended input at cycle N appears on the CDB at N+1. Worst case with
//    both sources saturated is N+1+2*DEPTH.
//  - Ordering: results from one producer are broadcast in arrival order (FIFO). There is
//    no ordering guarantee across producers.
//  - Queue: circular, head/tail of BUF_BIT bits wrapping mod DEPTH; count of BUF_BIT+1 bits.
//    Dequeue (grant of a non-empty queue) and enqueue in the same cycle: count unchanged.
//  - full = (count == DEPTH), combinational from registers. A valid on a full queue is
//    dropped; the bench flags it as a protocol error.
//    - At count==DEPTH-1 with a simultaneous enqueue and no dequeue, full rises next cycle.
//  - clear=1 (with rdy): queues emptied, cdb_valid <= 0, same-cycle inputs discarded,
//    last_grant kept.
//  - rdy=0: outputs hold their last value. Consumers are rdy-gated, so a held broadcast is
//    not re-consumed.
// STRUCTURE
//  - const.v: add `cdb_buf_bit (default 2) next to `robsize; the source encodings
//    `CDB_ALU=0 and `CDB_LSB=1 also go in const.v.
//  - Sub-module cdb_fifo (clk, rst, rdy, clear, push, push_tag, push_val, pop, head_*,
//    empty, full), instantiated twice. Arbiter, bypass mux and output register live in the
//    top level.
// TESTING
//  1. Reset: rst high 2 cycles -> cdb_valid=0, alu_full=lsb_full=0 on the cycle after
//     release.
//  2. Lone ALU: alu_valid, id=5, val=0x1234 at N -> at N+1 cdb_valid=1, id=5, val=0x1234,
//     src=0; at N+2 cdb_valid=0.
//  3. Collision: ALU(id3,0xA) and LSB(id7,0xB) at N, then idle -> N+1: id3 src0;
//     N+2: id7 src1; N+3: cdb_valid=0.
//  4. Saturation: both valid every cycle (ids 0..) until a full flag rises -> the bus
//     alternates ALU/LSB every cycle and each source stays in order. alu_full asserts once
//     the ALU has 4 results pending; it deasserts the cycle after its next grant.
//  5. Flush: queue 3 ALU results, assert clear with lsb_valid(id9) same cycle ->
//     next cycle cdb_valid=0, both queues empty; id9 is never broadcast.
//  6. Stall: rdy=0 for 3 cycles with a queued result -> cdb outputs and count unchanged;
//     after rdy=1 the broadcast resumes in the same order.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the common data bus arbiter.
// Holds the source encodings and the default queue depth and ROB tag width.
package cdb_arbiter_pkg;

  localparam int unsigned CdbBufBit = 2;
  localparam int unsigned RobW      = 5;

  typedef enum logic {
    CdbAlu = 1'b0,
    CdbLsb = 1'b1
  } cdb_src_e;

  function automatic cdb_src_e other_src(cdb_src_e s);
    return (s == CdbAlu) ? CdbLsb : CdbAlu;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side (ALU, LSB) and broadcast-side signals of the common data bus.
// The arbiter uses the master modport; producers and consumers use the slave modport.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned ROB_W = RobW
) ();

  logic             alu_valid;
  logic [ROB_W-1:0] alu_rob_id;
  logic [31:0]      alu_value;
  logic             alu_full;

  logic             lsb_valid;
  logic [ROB_W-1:0] lsb_rob_id;
  logic [31:0]      lsb_value;
  logic             lsb_full;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;
  logic             cdb_src;

  modport master (
    input  alu_valid, alu_rob_id, alu_value,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

  modport slave (
    output alu_valid, alu_rob_id, alu_value,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-producer circular result queue (tag + value) for the CDB arbiter.
// Pushes on a full queue are dropped; clear empties the queue and ignores push/pop.
module cdb_arbiter_fifo #(
  parameter int unsigned BUF_BIT = 2,
  parameter int unsigned ROB_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             push,
  input  logic [ROB_W-1:0] push_tag,
  input  logic [31:0]      push_val,
  input  logic             pop,
  output logic [ROB_W-1:0] head_tag,
  output logic [31:0]      head_val,
  output logic             empty,
  output logic             full
);

  localparam int unsigned Depth = 1 << BUF_BIT;
  localparam logic [BUF_BIT:0] DepthCnt = Depth[BUF_BIT:0];

  logic [ROB_W-1:0]   tag_q [Depth];
  logic [31:0]        val_q [Depth];
  logic [BUF_BIT-1:0] head_q, tail_q;
  logic [BUF_BIT:0]   count_q;
  logic               do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DepthCnt);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign head_tag = tag_q[head_q];
  assign head_val = val_q[head_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (clear) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) tail_q <= tail_q + 1'b1;
        if (do_pop)  head_q <= head_q + 1'b1;
        if (do_push && !do_pop) begin
          count_q <= count_q + 1'b1;
        end else if (!do_push && do_pop) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (rdy && do_push) begin
      tag_q[tail_q] <= push_tag;
      val_q[tail_q] <= push_val;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between the ALU and LSB result streams onto the single CDB.
// Each producer has a bypassable queue; the winner is broadcast from a register.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned BUF_BIT = CdbBufBit,
  parameter int unsigned ROB_W   = RobW
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          clear,
  cdb_arbiter_if.master bus
);

  logic [ROB_W-1:0] alu_head_tag, lsb_head_tag;
  logic [31:0]      alu_head_val, lsb_head_val;
  logic             alu_empty, lsb_empty;
  logic             alu_q_full, lsb_q_full;

  logic             alu_cand, lsb_cand, any_cand;
  logic [ROB_W-1:0] alu_cand_tag, lsb_cand_tag, win_tag;
  logic [31:0]      alu_cand_val, lsb_cand_val, win_val;
  cdb_src_e         winner;
  logic             alu_push, lsb_push, alu_pop, lsb_pop;

  cdb_src_e         last_grant_q;
  logic             cdb_valid_q;
  logic [ROB_W-1:0] cdb_rob_id_q;
  logic [31:0]      cdb_value_q;
  cdb_src_e         cdb_src_q;

  // Candidate is the queue head, or the incoming result when the queue is empty.
  assign alu_cand     = bus.alu_valid || !alu_empty;
  assign lsb_cand     = bus.lsb_valid || !lsb_empty;
  assign any_cand     = alu_cand || lsb_cand;
  assign alu_cand_tag = alu_empty ? bus.alu_rob_id : alu_head_tag;
  assign alu_cand_val = alu_empty ? bus.alu_value  : alu_head_val;
  assign lsb_cand_tag = lsb_empty ? bus.lsb_rob_id : lsb_head_tag;
  assign lsb_cand_val = lsb_empty ? bus.lsb_value  : lsb_head_val;

  always_comb begin
    winner = CdbAlu;
    if (alu_cand && lsb_cand) begin
      winner = other_src(last_grant_q);
    end else if (lsb_cand) begin
      winner = CdbLsb;
    end
  end

  assign win_tag = (winner == CdbAlu) ? alu_cand_tag : lsb_cand_tag;
  assign win_val = (winner == CdbAlu) ? alu_cand_val : lsb_cand_val;

  assign alu_pop  = any_cand && (winner == CdbAlu) && !alu_empty;
  assign lsb_pop  = any_cand && (winner == CdbLsb) && !lsb_empty;
  // Incoming result is queued unless it was bypassed straight onto the bus.
  assign alu_push = bus.alu_valid && (!alu_empty || (winner != CdbAlu));
  assign lsb_push = bus.lsb_valid && (!lsb_empty || (winner != CdbLsb));

  cdb_arbiter_fifo #(
    .BUF_BIT (BUF_BIT),
    .ROB_W   (ROB_W)
  ) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (clear),
    .push     (alu_push),
    .push_tag (bus.alu_rob_id),
    .push_val (bus.alu_value),
    .pop      (alu_pop),
    .head_tag (alu_head_tag),
    .head_val (alu_head_val),
    .empty    (alu_empty),
    .full     (alu_q_full)
  );

  cdb_arbiter_fifo #(
    .BUF_BIT (BUF_BIT),
    .ROB_W   (ROB_W)
  ) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (clear),
    .push     (lsb_push),
    .push_tag (bus.lsb_rob_id),
    .push_val (bus.lsb_value),
    .pop      (lsb_pop),
    .head_tag (lsb_head_tag),
    .head_val (lsb_head_val),
    .empty    (lsb_empty),
    .full     (lsb_q_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= CdbAlu;
      last_grant_q <= CdbLsb;
    end else if (rdy) begin
      if (clear) begin
        cdb_valid_q <= 1'b0;
      end else if (any_cand) begin
        cdb_valid_q  <= 1'b1;
        cdb_rob_id_q <= win_tag;
        cdb_value_q  <= win_val;
        cdb_src_q    <= winner;
        last_grant_q <= winner;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_full   = alu_q_full;
  assign bus.lsb_full   = lsb_q_full;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_value  = cdb_value_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic checked against
// a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned W     = RobW;
  localparam int unsigned Depth = 1 << CdbBufBit;

  logic clk, rst, rdy, clear;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus.master)
  );

  typedef struct {
    logic [W-1:0] id;
    logic [31:0]  val;
  } res_t;

  res_t         aq[$];
  res_t         lq[$];
  logic         m_valid, m_src, m_last;
  logic [W-1:0] m_id;
  logic [31:0]  m_val;
  int           n_cmp, n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: enqueue every accepted input, then grant one queue front per cycle.
  task automatic model_step(input logic r, input logic rd, input logic clr,
                            input logic av, input logic [W-1:0] aid, input logic [31:0] aval,
                            input logic lv, input logic [W-1:0] lid, input logic [31:0] lval);
    res_t e;
    logic ha, hl, win;
    if (r) begin
      aq.delete();
      lq.delete();
      m_valid = 1'b0;
      m_id    = '0;
      m_val   = '0;
      m_src   = 1'b0;
      m_last  = 1'b1;
    end else if (rd) begin
      if (clr) begin
        aq.delete();
        lq.delete();
        m_valid = 1'b0;
      end else begin
        if (av && aq.size() < Depth) begin
          e.id = aid; e.val = aval; aq.push_back(e);
        end
        if (lv && lq.size() < Depth) begin
          e.id = lid; e.val = lval; lq.push_back(e);
        end
        ha = (aq.size() != 0);
        hl = (lq.size() != 0);
        if (ha || hl) begin
          win = (ha && hl) ? !m_last : hl;
          e = win ? lq.pop_front() : aq.pop_front();
          m_valid = 1'b1;
          m_id    = e.id;
          m_val   = e.val;
          m_src   = win;
          m_last  = win;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic rd, input logic clr,
                      input logic av, input logic [W-1:0] aid, input logic [31:0] aval,
                      input logic lv, input logic [W-1:0] lid, input logic [31:0] lval);
    rst = r; rdy = rd; clear = clr;
    bus.alu_valid = av; bus.alu_rob_id = aid; bus.alu_value = aval;
    bus.lsb_valid = lv; bus.lsb_rob_id = lid; bus.lsb_value = lval;
    @(posedge clk);
    model_step(r, rd, clr, av, aid, aval, lv, lid, lval);
    #1;
    check_eq("cdb_valid", bus.cdb_valid, m_valid);
    check_eq("cdb_rob_id", bus.cdb_rob_id, m_id);
    check_eq("cdb_value", bus.cdb_value, m_val);
    check_eq("cdb_src", bus.cdb_src, m_src);
    check_eq("alu_full", bus.alu_full, aq.size() == Depth);
    check_eq("lsb_full", bus.lsb_full, lq.size() == Depth);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic reset_dut();
    tick(1, 1, 0, 0, '0, '0, 0, '0, '0);
    tick(1, 1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic both(input int k);
    tick(0, 1, 0, 1, W'(k), 32'hA000 + k, 1, W'(k + 16), 32'hB000 + k);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1; m_id = '0; m_val = '0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_value = '0;
    bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_value = '0;

    // Reset
    reset_dut();
    check_eq("rst_valid", bus.cdb_valid, 1'b0);
    check_eq("rst_alu_full", bus.alu_full, 1'b0);
    check_eq("rst_lsb_full", bus.lsb_full, 1'b0);

    // Lone ALU result bypasses in one cycle
    tick(0, 1, 0, 1, W'(5), 32'h1234, 0, '0, '0);
    check_eq("lone_valid", bus.cdb_valid, 1'b1);
    check_eq("lone_id", bus.cdb_rob_id, 5);
    check_eq("lone_val", bus.cdb_value, 32'h1234);
    check_eq("lone_src", bus.cdb_src, 1'b0);
    idle(1);
    check_eq("lone_idle", bus.cdb_valid, 1'b0);

    // Collision after reset: ALU wins the first tie
    reset_dut();
    tick(0, 1, 0, 1, W'(3), 32'hA, 1, W'(7), 32'hB);
    check_eq("col1_id", bus.cdb_rob_id, 3);
    check_eq("col1_src", bus.cdb_src, 1'b0);
    idle(1);
    check_eq("col2_id", bus.cdb_rob_id, 7);
    check_eq("col2_src", bus.cdb_src, 1'b1);
    idle(1);
    check_eq("col3_valid", bus.cdb_valid, 1'b0);

    // Saturation: grants alternate until a queue fills
    reset_dut();
    for (int k = 0; k < 32; k++) begin
      if (aq.size() == Depth || lq.size() == Depth) break;
      both(k);
      check_eq("sat_alt", bus.cdb_src, k % 2);
    end
    check_eq("sat_full", bus.alu_full | bus.lsb_full, 1'b1);
    idle(2 * Depth + 4);

    // Flush with a same-cycle LSB result
    reset_dut();
    for (int k = 0; k < 6; k++) both(k);
    tick(0, 1, 1, 0, '0, '0, 1, W'(9), 32'h9999);
    check_eq("flush_valid", bus.cdb_valid, 1'b0);
    check_eq("flush_alu_full", bus.alu_full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("flush_quiet", bus.cdb_valid, 1'b0);
    end

    // Stall with queued results, inputs ignored while rdy is low
    reset_dut();
    for (int k = 0; k < 4; k++) both(k);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, W'(20 + i), 32'hDEAD, 1, W'(25 + i), 32'hBEEF);
    idle(2 * Depth + 2);

    // Random traffic
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      logic rd, clr, av, lv;
      rd  = ($urandom_range(4) != 0);
      clr = ($urandom_range(39) == 0);
      av  = ($urandom_range(1) == 1) && (aq.size() < Depth);
      lv  = ($urandom_range(2) != 0) && (lq.size() < Depth);
      tick(0, rd, clr, av, W'($urandom), $urandom, lv, W'($urandom), $urandom);
    end
    idle(2 * Depth + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
